imm_gen_pipe: RTL and testbench

//  Parametrised, pipelined immediate generator for the ID stage. Decodes all RV32I/RV64I

---
 rtl/imm_gen_pipe_pkg.sv | 32 +++
 rtl/imm_gen_pipe_decode.sv | 47 ++++
 rtl/imm_gen_pipe.sv | 99 +++++++++
 tb/tb_imm_gen_pipe.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imm_gen_pipe_pkg.sv
// Shared opcode constants, immediate-format encoding and parameter legality helpers
// for the pipelined immediate generator.
package imm_pkg;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_SH   = 3'd2,
    FMT_S    = 3'd3,
    FMT_B    = 3'd4,
    FMT_U    = 3'd5,
    FMT_J    = 3'd6
  } fmt_e;

  function automatic bit xlen_legal(input int unsigned xlen);
    return (xlen == 32) || (xlen == 64);
  endfunction

  function automatic bit depth_legal(input int unsigned depth);
    return (depth >= 1) && (depth <= 3);
  endfunction

endpackage

// File: rtl/imm_gen_pipe_decode.sv
// Combinational RV32I/RV64I immediate decoder: instruction word -> {imm, fmt}.
// Every format is first built as a 32-bit value, then sign-extended to XLEN.
module imm_decode
  import imm_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [31:0]     instr_i,
  output logic [XLEN-1:0] imm_o,
  output fmt_e            fmt_o
);

  logic [31:0] imm32;

  always_comb begin
    fmt_o = FMT_NONE;
    unique case (instr_i[6:0])
      // funct3 001 (slli) and 101 (srli/srai) share low bits 01
      OPC_OP_IMM:         fmt_o = (instr_i[13:12] == 2'b01) ? FMT_SH : FMT_I;
      OPC_LOAD, OPC_JALR: fmt_o = FMT_I;
      OPC_STORE:          fmt_o = FMT_S;
      OPC_BRANCH:         fmt_o = FMT_B;
      OPC_LUI, OPC_AUIPC: fmt_o = FMT_U;
      OPC_JAL:            fmt_o = FMT_J;
      default:            fmt_o = FMT_NONE;
    endcase
  end

  always_comb begin
    imm32 = '0;
    case (fmt_o)
      FMT_I:   imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
      // shamt is zero-extended; bit 31 of imm32 stays 0 so the final extension is a no-op
      FMT_SH:  imm32 = (XLEN == 64) ? {26'b0, instr_i[25:20]} : {27'b0, instr_i[24:20]};
      FMT_S:   imm32 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
      FMT_B:   imm32 = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                        instr_i[11:8], 1'b0};
      FMT_U:   imm32 = {instr_i[31:12], 12'b0};
      FMT_J:   imm32 = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                        instr_i[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  assign imm_o = XLEN'($signed(imm32));

endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator: decode + pc-relative target, PIPE_DEPTH register stages.
// Stall freezes every stage and ignores inputs; flush kills all stages and wins over stall.
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int unsigned XLEN          = 32,
  parameter int unsigned PIPE_DEPTH    = 1,
  parameter bit          ZERO_ON_FLUSH = 1'b1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            valid_i,
  input  logic            stall_i,
  input  logic            flush_i,
  input  logic [31:0]     instr_i,
  input  logic [XLEN-1:0] pc_i,
  output logic            valid_o,
  output logic [XLEN-1:0] imm_o,
  output logic [2:0]      fmt_o,
  output logic [XLEN-1:0] target_o,
  output logic            illegal_o
);

  if (!xlen_legal(XLEN)) begin : g_bad_xlen
    $error("imm_gen_pipe: XLEN must be 32 or 64");
  end
  if (!depth_legal(PIPE_DEPTH)) begin : g_bad_depth
    $error("imm_gen_pipe: PIPE_DEPTH must be 1..3");
  end

  typedef struct packed {
    logic            vld;
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic [XLEN-1:0] target;
    logic            illegal;
  } stage_t;

  logic [XLEN-1:0] dec_imm;
  fmt_e            dec_fmt;
  stage_t          dec_s;

  // link[0] is the decoder result, link[k+1] is the output of stage k
  stage_t [PIPE_DEPTH:0] link;

  imm_decode #(
    .XLEN (XLEN)
  ) u_decode (
    .instr_i (instr_i),
    .imm_o   (dec_imm),
    .fmt_o   (dec_fmt)
  );

  always_comb begin
    dec_s         = '0;
    dec_s.vld     = valid_i;
    dec_s.imm     = dec_imm;
    dec_s.fmt     = dec_fmt;
    dec_s.target  = pc_i + dec_imm;
    dec_s.illegal = valid_i && (dec_fmt == FMT_NONE);
  end

  assign link[0] = dec_s;

  for (genvar k = 0; k < PIPE_DEPTH; k++) begin : g_stage
    stage_t stg_d;
    stage_t stg_q;

    always_comb begin
      stg_d = stg_q;
      if (flush_i) begin
        stg_d.vld     = 1'b0;
        stg_d.illegal = 1'b0;
        if (ZERO_ON_FLUSH) begin
          stg_d = '0;
        end
      end else if (!stall_i) begin
        stg_d = link[k];
      end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
        stg_q <= '0;
      end else begin
        stg_q <= stg_d;
      end
    end

    assign link[k+1] = stg_q;
  end

  assign valid_o   = link[PIPE_DEPTH].vld;
  assign imm_o     = link[PIPE_DEPTH].imm;
  assign fmt_o     = link[PIPE_DEPTH].fmt;
  assign target_o  = link[PIPE_DEPTH].target;
  assign illegal_o = link[PIPE_DEPTH].illegal;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench: depth-1 XLEN=32, depth-1 XLEN=64 and depth-3 XLEN=32 instances share stimulus.
module tb_imm_gen_pipe;

  logic        clk;
  logic        rst_n;
  logic        valid;
  logic        stall;
  logic        flush;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [63:0] pc64;

  logic        v1, ill1;
  logic [31:0] imm1, tgt1;
  logic [2:0]  fmt1;
  logic        v64, ill64;
  logic [63:0] imm64, tgt64;
  logic [2:0]  fmt64;
  logic        v3, ill3;
  logic [31:0] imm3, tgt3;
  logic [2:0]  fmt3;

  int errors = 0;
  int checks = 0;

  assign pc64 = {32'h0, pc};

  imm_gen_pipe #(.XLEN(32), .PIPE_DEPTH(1), .ZERO_ON_FLUSH(1'b1)) u_d1 (
    .clk_i(clk), .rst_i(rst_n), .valid_i(valid), .stall_i(stall), .flush_i(flush),
    .instr_i(instr), .pc_i(pc), .valid_o(v1), .imm_o(imm1), .fmt_o(fmt1),
    .target_o(tgt1), .illegal_o(ill1)
  );

  imm_gen_pipe #(.XLEN(64), .PIPE_DEPTH(1), .ZERO_ON_FLUSH(1'b1)) u_d64 (
    .clk_i(clk), .rst_i(rst_n), .valid_i(valid), .stall_i(stall), .flush_i(flush),
    .instr_i(instr), .pc_i(pc64), .valid_o(v64), .imm_o(imm64), .fmt_o(fmt64),
    .target_o(tgt64), .illegal_o(ill64)
  );

  imm_gen_pipe #(.XLEN(32), .PIPE_DEPTH(3), .ZERO_ON_FLUSH(1'b1)) u_d3 (
    .clk_i(clk), .rst_i(rst_n), .valid_i(valid), .stall_i(stall), .flush_i(flush),
    .instr_i(instr), .pc_i(pc), .valid_o(v3), .imm_o(imm3), .fmt_o(fmt3),
    .target_o(tgt3), .illegal_o(ill3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] addi(input int k);
    logic [31:0] kv;
    kv = k;
    return {kv[11:0], 5'd0, 3'b000, 5'd1, 7'b0010011};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; valid = 1'b0; stall = 1'b0; flush = 1'b0; instr = '0; pc = '0;
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({v1, imm1, fmt1, tgt1, ill1} !== '0) begin
      errors++; $display("FAIL reset_d1 got=%h exp=0", {v1, imm1, fmt1, tgt1, ill1});
    end
    checks++;
    if ({v64, imm64, fmt64, tgt64, ill64} !== '0) begin
      errors++; $display("FAIL reset_d64 got=%h exp=0", {v64, imm64, fmt64, tgt64, ill64});
    end
    checks++;
    if ({v3, imm3, fmt3, tgt3, ill3} !== '0) begin
      errors++; $display("FAIL reset_d3 got=%h exp=0", {v3, imm3, fmt3, tgt3, ill3});
    end
    valid = 1'b1; instr = addi(5);
    tick(); tick();
    checks++;
    if ({v1, imm1, v3, imm3} !== '0) begin
      errors++; $display("FAIL reset_hold got=%h exp=0", {v1, imm1, v3, imm3});
    end
    valid = 1'b0;
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [31:0] ins;
    logic [31:0] pcv;
    logic [31:0] imm;
    logic [2:0]  fmt;
    logic        ill;
    logic        chk;
    logic [31:0] tgt;
  } vec_t;

  task automatic test_formats();
    vec_t tbl[12];
    tbl = '{
      '{32'hFFF00093, 32'h0,        32'hFFFFFFFF, 3'd1, 1'b0, 1'b0, 32'h0},
      '{32'hFE20AE23, 32'h0,        32'hFFFFFFFC, 3'd3, 1'b0, 1'b0, 32'h0},
      '{32'h123450B7, 32'h0,        32'h12345000, 3'd5, 1'b0, 1'b0, 32'h0},
      '{32'h4030D093, 32'h0,        32'h00000003, 3'd2, 1'b0, 1'b0, 32'h0},
      '{32'h01F09093, 32'h0,        32'h0000001F, 3'd2, 1'b0, 1'b0, 32'h0},
      '{32'hFE000CE3, 32'h100,      32'hFFFFFFF8, 3'd4, 1'b0, 1'b1, 32'h000000F8},
      '{32'h0010006F, 32'hFFFFF800, 32'h00000800, 3'd6, 1'b0, 1'b1, 32'h00000000},
      '{32'h00209863, 32'h200,      32'h00000010, 3'd4, 1'b0, 1'b1, 32'h00000210},
      '{32'h00812083, 32'h0,        32'h00000008, 3'd1, 1'b0, 1'b0, 32'h0},
      '{32'hFF0100E7, 32'h0,        32'hFFFFFFF0, 3'd1, 1'b0, 1'b0, 32'h0},
      '{32'hFFFFF097, 32'h0,        32'hFFFFF000, 3'd5, 1'b0, 1'b0, 32'h0},
      '{32'h0000000B, 32'h0,        32'h00000000, 3'd0, 1'b1, 1'b0, 32'h0}
    };
    for (int i = 0; i < 12; i++) begin
      valid = 1'b1; instr = tbl[i].ins; pc = tbl[i].pcv;
      tick();
      checks++;
      if ({v1, imm1, fmt1, ill1} !== {1'b1, tbl[i].imm, tbl[i].fmt, tbl[i].ill}) begin
        errors++;
        $display("FAIL fmt_row%0d got v=%b imm=%h fmt=%0d ill=%b exp v=1 imm=%h fmt=%0d ill=%b",
                 i, v1, imm1, fmt1, ill1, tbl[i].imm, tbl[i].fmt, tbl[i].ill);
      end
      if (tbl[i].chk) begin
        checks++;
        if (tgt1 !== tbl[i].tgt) begin
          errors++; $display("FAIL target_row%0d got=%h exp=%h", i, tgt1, tbl[i].tgt);
        end
      end
    end
    valid = 1'b0;
  endtask

  typedef struct {
    logic [31:0] ins;
    logic [31:0] pcv;
    logic [31:0] imm32;
    logic [63:0] imm64;
    logic [2:0]  fmt;
    logic        chk;
    logic [63:0] tgt64;
  } vec64_t;

  task automatic test_xlen64();
    vec64_t tbl[6];
    tbl = '{
      '{32'h4030D093, 32'h0,        32'h3,        64'h3,                 3'd2, 1'b0, 64'h0},
      '{32'h4230D093, 32'h0,        32'h3,        64'h23,                3'd2, 1'b0, 64'h0},
      '{32'h800000B7, 32'h0,        32'h80000000, 64'hFFFFFFFF80000000, 3'd5, 1'b0, 64'h0},
      '{32'hFFF00093, 32'h0,        32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 3'd1, 1'b0, 64'h0},
      '{32'h0010006F, 32'hFFFFF800, 32'h800,      64'h800,               3'd6, 1'b1, 64'h100000000},
      '{32'hFE000CE3, 32'h100,      32'hFFFFFFF8, 64'hFFFFFFFFFFFFFFF8, 3'd4, 1'b1, 64'hF8}
    };
    for (int i = 0; i < 6; i++) begin
      valid = 1'b1; instr = tbl[i].ins; pc = tbl[i].pcv;
      tick();
      checks++;
      if ({v64, imm64, fmt64} !== {1'b1, tbl[i].imm64, tbl[i].fmt}) begin
        errors++;
        $display("FAIL x64_row%0d got v=%b imm=%h fmt=%0d exp v=1 imm=%h fmt=%0d",
                 i, v64, imm64, fmt64, tbl[i].imm64, tbl[i].fmt);
      end
      checks++;
      if (imm1 !== tbl[i].imm32) begin
        errors++; $display("FAIL x32_row%0d got=%h exp=%h", i, imm1, tbl[i].imm32);
      end
      if (tbl[i].chk) begin
        checks++;
        if (tgt64 !== tbl[i].tgt64) begin
          errors++; $display("FAIL x64_target%0d got=%h exp=%h", i, tgt64, tbl[i].tgt64);
        end
      end
    end
    valid = 1'b0; pc = '0;
  endtask

  task automatic test_stall_stream();
    logic [31:0] got[$];
    logic [19:0] pat;
    logic        snap_v;
    logic [31:0] snap_imm;
    int          k;
    int          first_c;
    logic        st;
    pat = 20'b0000_0000_0000_0110_0000;
    flush = 1'b1; valid = 1'b0;
    tick();
    flush = 1'b0;
    k = 1; first_c = -1;
    for (int c = 0; c < 20; c++) begin
      valid = (k <= 6); instr = addi(k); st = pat[c]; stall = st;
      snap_v = v3; snap_imm = imm3;
      tick();
      if (st) begin
        checks++;
        if ({v3, imm3} !== {snap_v, snap_imm}) begin
          errors++;
          $display("FAIL stall_frozen c=%0d got v=%b imm=%h exp v=%b imm=%h",
                   c, v3, imm3, snap_v, snap_imm);
        end
      end else begin
        if (k <= 6) k++;
        if (v3) begin
          got.push_back(imm3);
          if (first_c < 0) first_c = c;
        end
      end
    end
    stall = 1'b0; valid = 1'b0;
    checks++;
    if (first_c !== 2) begin
      errors++; $display("FAIL stream_latency got first_cycle=%0d exp=2", first_c);
    end
    checks++;
    if (got.size() !== 6) begin
      errors++; $display("FAIL stream_count got=%0d exp=6", got.size());
    end
    for (int i = 0; i < got.size(); i++) begin
      checks++;
      if (got[i] !== 32'(i + 1)) begin
        errors++; $display("FAIL stream_order idx=%0d got=%h exp=%h", i, got[i], i + 1);
      end
    end
  endtask

  task automatic test_flush_stall();
    for (int i = 10; i < 13; i++) begin
      valid = 1'b1; instr = addi(i);
      tick();
    end
    checks++;
    if ({v3, imm3} !== {1'b1, 32'd10}) begin
      errors++; $display("FAIL fill_d3 got v=%b imm=%h exp v=1 imm=a", v3, imm3);
    end
    flush = 1'b1; stall = 1'b1; valid = 1'b1; instr = addi(99);
    tick();
    flush = 1'b0; stall = 1'b0;
    for (int j = 0; j < 3; j++) begin
      checks++;
      if ({v3, imm3, fmt3, tgt3, ill3} !== '0) begin
        errors++; $display("FAIL flush_zero j=%0d got=%h exp=0", j, {v3, imm3, fmt3, tgt3, ill3});
      end
      valid = (j == 0); instr = (j == 0) ? addi(50) : addi(51);
      tick();
    end
    checks++;
    if ({v3, imm3, fmt3} !== {1'b1, 32'd50, 3'd1}) begin
      errors++; $display("FAIL after_flush got v=%b imm=%h fmt=%0d exp v=1 imm=32 fmt=1",
                         v3, imm3, fmt3);
    end
    valid = 1'b0;
  endtask

  task automatic test_illegal();
    valid = 1'b1; instr = 32'h0000000B;
    tick();
    valid = 1'b0;
    tick(); tick();
    checks++;
    if ({v3, ill3, fmt3, imm3} !== {1'b1, 1'b1, 3'd0, 32'd0}) begin
      errors++; $display("FAIL illegal_d3 got v=%b ill=%b fmt=%0d imm=%h exp v=1 ill=1 fmt=0 imm=0",
                         v3, ill3, fmt3, imm3);
    end
    tick();
    checks++;
    if ({v3, ill3} !== 2'b00) begin
      errors++; $display("FAIL illegal_bubble got v=%b ill=%b exp 0 0", v3, ill3);
    end
  endtask

  task automatic test_reset_midstream();
    for (int i = 1; i < 4; i++) begin
      valid = 1'b1; instr = addi(i);
      tick();
    end
    checks++;
    if (v3 !== 1'b1) begin
      errors++; $display("FAIL pre_reset_fill got v=%b exp 1", v3);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({v3, imm3, fmt3, tgt3, ill3} !== '0) begin
      errors++; $display("FAIL midreset_d3 got=%h exp=0", {v3, imm3, fmt3, tgt3, ill3});
    end
    checks++;
    if ({v1, imm1, fmt1, tgt1, ill1} !== '0) begin
      errors++; $display("FAIL midreset_d1 got=%h exp=0", {v1, imm1, fmt1, tgt1, ill1});
    end
    #1 rst_n = 1'b1;
    valid = 1'b1; instr = addi(7);
    tick();
    valid = 1'b0;
    checks++;
    if ({v1, imm1, v3} !== {1'b1, 32'd7, 1'b0}) begin
      errors++; $display("FAIL release_edge1 got v1=%b imm1=%h v3=%b exp 1 7 0", v1, imm1, v3);
    end
    tick();
    checks++;
    if (v3 !== 1'b0) begin
      errors++; $display("FAIL release_edge2 got v3=%b exp 0", v3);
    end
    tick();
    checks++;
    if ({v3, imm3} !== {1'b1, 32'd7}) begin
      errors++; $display("FAIL release_edge3 got v=%b imm=%h exp v=1 imm=7", v3, imm3);
    end
  endtask

  initial begin
    test_reset();
    test_formats();
    test_xlen64();
    test_stall_stream();
    test_flush_stall();
    test_illegal();
    test_reset_midstream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
